// File: rtl/ora_misr.sv
// LBIST output response analyser: compacts CUT responses into a Galois MISR
// and compares the final signature against GOLDEN. Optional macro: ORA_MASK_EN.
module ora_misr #(
  parameter int unsigned        SBITS  = 4,
  parameter int unsigned        RBITS  = 4,
  parameter logic [SBITS-1:0]   POLY   = 4'h3,
  parameter logic [SBITS-1:0]   SEED   = 4'h0,
  parameter logic [SBITS-1:0]   GOLDEN = 4'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic             RESP_VALID,
  input  logic [RBITS-1:0] RESPONSE,
`ifdef ORA_MASK_EN
  input  logic [RBITS-1:0] MASK,
`endif
  input  logic             END,
  output logic [SBITS-1:0] SIGNATURE,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPACT = 2'd1;
  localparam logic [1:0] S_COMPARE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       r_state;
  logic [SBITS-1:0] r_sig;
  logic             r_done;
  logic             r_pass;

  logic [RBITS-1:0] w_resp;
  logic [SBITS-1:0] w_r;
  logic [SBITS-1:0] w_fb;
  logic [SBITS-1:0] w_next;

`ifdef ORA_MASK_EN
  // X-prone CUT outputs are forced to zero before compaction
  assign w_resp = RESPONSE & ~MASK;
`else
  assign w_resp = RESPONSE;
`endif

  // Galois step: shift, fold the MSB back through the taps, XOR response in
  assign w_r    = SBITS'(w_resp);
  assign w_fb   = r_sig[SBITS-1] ? POLY : '0;
  assign w_next = {r_sig[SBITS-2:0], 1'b0} ^ w_fb ^ w_r;

  // Session FSM; START overrides everything, including a same-cycle END
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else if (START) begin
      r_state <= S_COMPACT;
      r_sig   <= SEED;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_COMPACT: begin
          if (RESP_VALID) r_sig <= w_next;
          if (END) r_state <= S_COMPARE;
        end
        S_COMPARE: begin
          r_pass  <= (r_sig == GOLDEN);
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_IDLE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign SIGNATURE = r_sig;
  assign BUSY      = (r_state == S_COMPACT) || (r_state == S_COMPARE);
  assign DONE      = r_done;
  assign PASS      = r_pass;

endmodule

// File: tb/tb_ora_misr.sv
// Bench for ora_misr: signature-level model plus directed vectors.
// Build with ORA_MASK_EN to also exercise the response mask.
module tb_ora_misr;

  localparam logic [3:0] POLY   = 4'h3;
  localparam logic [3:0] SEED   = 4'h0;
  localparam logic [3:0] GOLDEN = 4'h3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       t_start = 1'b0;
  logic       t_valid = 1'b0;
  logic [3:0] t_resp = 4'h0;
  logic [3:0] t_mask = 4'h0;
  logic       t_end = 1'b0;
  logic [3:0] SIGNATURE;
  logic       BUSY, DONE, PASS;

  int total = 0;
  int bad   = 0;

  ora_misr #(
    .SBITS(4), .RBITS(4), .POLY(POLY), .SEED(SEED), .GOLDEN(GOLDEN)
  ) dut (
    .clk(clk), .rst(rst), .START(t_start), .RESP_VALID(t_valid),
    .RESPONSE(t_resp),
`ifdef ORA_MASK_EN
    .MASK(t_mask),
`endif
    .END(t_end), .SIGNATURE(SIGNATURE), .BUSY(BUSY), .DONE(DONE),
    .PASS(PASS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // signature as a polynomial: multiply by x modulo x^4+x+1, then add r
  function automatic logic [3:0] step(input logic [3:0] s,
                                      input logic [3:0] r);
    int t;
    t = int'(s) * 2;
    if (t >= 16) t = t ^ (16 + int'(POLY));
    return 4'(t) ^ r;
  endfunction

  // session model: compacting flag and clocks elapsed since END
  logic [3:0] m_sig = SEED;
  logic       m_cmp = 1'b0;
  int         m_age = -1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sig = SEED; m_cmp = 1'b0; m_age = -1;
    end else if (t_start) begin
      m_sig = SEED; m_cmp = 1'b1; m_age = -1;
    end else if (m_cmp) begin
      if (t_valid) m_sig = step(m_sig, t_resp & ~t_mask);
      if (t_end) begin
        m_cmp = 1'b0; m_age = 0;
      end
    end else if (m_age >= 0 && m_age < 2) begin
      m_age++;
    end
  end

  // outputs checked every cycle; the settling cycle after END is skipped
  always @(negedge clk) begin
    logic e_done;
    chk("cmp_sig", 32'(SIGNATURE), 32'(m_sig));
    if (m_age != 1) begin
      e_done = (m_age >= 2);
      chk("cmp_busy", 32'(BUSY), 32'(m_cmp || m_age == 0));
      chk("cmp_done", 32'(DONE), 32'(e_done));
      if (e_done)
        chk("cmp_pass", 32'(PASS), 32'(m_sig == GOLDEN));
      else
        chk("cmp_pass0", 32'(PASS), 32'(0));
    end
  end

  task automatic cyc(input logic s, input logic v, input logic [3:0] d,
                     input logic e);
    t_start = s; t_valid = v; t_resp = d; t_end = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic async_rst(input string nm);
    rst = 1'b1;
    #1;
    chk({nm, "_sig"}, 32'(SIGNATURE), 32'(SEED));
    chk({nm, "_busy"}, 32'(BUSY), 32'(0));
    chk({nm, "_done"}, 32'(DONE), 32'(0));
    chk({nm, "_pass"}, 32'(PASS), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_sig", 32'(SIGNATURE), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'(0));
    chk("rst_done", 32'(DONE), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // IDLE ignores responses and END
    cyc(1'b0, 1'b1, 4'h5, 1'b1);
    chk("idle_sig", 32'(SIGNATURE), 32'h0);
    chk("idle_busy", 32'(BUSY), 32'(0));

    // 1,2,3 -> 1,0,3 ; matches golden
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    chk("t2_busy", 32'(BUSY), 32'(1));
    cyc(1'b0, 1'b1, 4'h1, 1'b0);
    chk("t2_s1", 32'(SIGNATURE), 32'h1);
    cyc(1'b0, 1'b1, 4'h2, 1'b0);
    chk("t2_s2", 32'(SIGNATURE), 32'h0);
    cyc(1'b0, 1'b1, 4'h3, 1'b1);
    chk("t2_s3", 32'(SIGNATURE), 32'h3);
    chk("t2_nodone", 32'(DONE), 32'(0));
    idle(2);
    chk("t2_done", 32'(DONE), 32'(1));
    chk("t2_pass", 32'(PASS), 32'(1));
    idle(2);
    chk("t2_hold", 32'(DONE), 32'(1));

    // reset from DONE and mid-compaction, no clock edge needed
    async_rst("t1a");
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'h5, 1'b0);
    chk("t1_pre", 32'(SIGNATURE), 32'h5);
    async_rst("t1b");

    // 1,2,7 -> 7 ; mismatch
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'h1, 1'b0);
    cyc(1'b0, 1'b1, 4'h2, 1'b0);
    cyc(1'b0, 1'b1, 4'h7, 1'b1);
    idle(2);
    chk("t3_sig", 32'(SIGNATURE), 32'h7);
    chk("t3_done", 32'(DONE), 32'(1));
    chk("t3_pass", 32'(PASS), 32'(0));

    // feedback: 8 then 0 -> 3 ; END held high afterwards has no effect
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'h8, 1'b0);
    chk("t4_s1", 32'(SIGNATURE), 32'h8);
    cyc(1'b0, 1'b1, 4'h0, 1'b1);
    chk("t4_s2", 32'(SIGNATURE), 32'h3);
    cyc(1'b0, 1'b1, 4'h5, 1'b1);
    cyc(1'b0, 1'b1, 4'h5, 1'b1);
    cyc(1'b0, 1'b1, 4'h5, 1'b1);
    chk("t4_sig", 32'(SIGNATURE), 32'h3);
    chk("t4_pass", 32'(PASS), 32'(1));

    // gaps hold the signature; START+END restarts and END is ignored
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'h1, 1'b0);
    cyc(1'b0, 1'b0, 4'h9, 1'b0);
    chk("t5_gap1", 32'(SIGNATURE), 32'h1);
    cyc(1'b0, 1'b1, 4'h2, 1'b0);
    cyc(1'b0, 1'b0, 4'hf, 1'b0);
    chk("t5_gap2", 32'(SIGNATURE), 32'h0);
    cyc(1'b0, 1'b1, 4'h3, 1'b0);
    chk("t5_s3", 32'(SIGNATURE), 32'h3);
    cyc(1'b1, 1'b1, 4'h9, 1'b1);
    chk("t5_reseed", 32'(SIGNATURE), 32'h0);
    idle(3);
    chk("t5_busy", 32'(BUSY), 32'(1));
    chk("t5_nodone", 32'(DONE), 32'(0));
    cyc(1'b0, 1'b1, 4'h1, 1'b0);
    cyc(1'b0, 1'b1, 4'h2, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b1);
    chk("t5_noupd", 32'(SIGNATURE), 32'h0);
    idle(2);
    chk("t5_done", 32'(DONE), 32'(1));
    chk("t5_pass", 32'(PASS), 32'(0));

    // abort during COMPARE
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'h3, 1'b1);
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    idle(3);
    chk("abort_sig", 32'(SIGNATURE), 32'h0);
    chk("abort_done", 32'(DONE), 32'(0));

`ifdef ORA_MASK_EN
    // bit 2 masked: 7 compacts as 3
    t_mask = 4'h4;
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'h1, 1'b0);
    cyc(1'b0, 1'b1, 4'h2, 1'b0);
    cyc(1'b0, 1'b1, 4'h7, 1'b1);
    idle(2);
    chk("t6_sig", 32'(SIGNATURE), 32'h3);
    chk("t6_pass", 32'(PASS), 32'(1));
    t_mask = 4'h0;
`endif

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
